keccak_round_ctrl: RTL and testbench

Round scheduler for the Keccak-f permutation datapath. It runs the five per-round step units (theta, rho, pi, chi, addRC) in sequence over NUM_ROUNDS rounds. Each unit is launched with a one-cycle start pulse and the controller waits for that unit's finish. The controller drives the shared round index that addRC and the other step units consume, and tags each job with the input file index supplied by the top level.

---
 rtl/keccak_round_ctrl_if.sv | 23 ++
 rtl/keccak_round_ctrl.sv | 149 ++++++++++++++
 tb/tb_keccak_round_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/keccak_round_ctrl_if.sv
// Handshake bundle between the top level, the Keccak step units and the round scheduler.
// The master side drives job requests and finish levels; the slave side is the controller.
interface keccak_round_ctrl_if;
  logic       start;
  logic [9:0] file_index_in;
  logic [4:0] step_finish;
  logic [4:0] step_start;
  logic [4:0] iteration;
  logic [9:0] file_index;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output start, file_index_in, step_finish,
    input  step_start, iteration, file_index, busy, done, error
  );

  modport slave (
    input  start, file_index_in, step_finish,
    output step_start, iteration, file_index, busy, done, error
  );
endinterface

// File: rtl/keccak_round_ctrl.sv
// Keccak-f round scheduler: launches theta, rho, pi, chi and addRC in turn for NUM_ROUNDS
// rounds, waiting on each unit's finish level with a per-step timeout.
module keccak_round_ctrl #(
  parameter int NUM_ROUNDS = 24,
  parameter int TIMEOUT    = 1023
) (
  input  logic               clk,
  input  logic               rst_n,
  keccak_round_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS - 1);
  localparam logic [9:0] WCNT_LAST  = 10'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic [4:0] iteration_q, iteration_d;
  logic [9:0] wcnt_q, wcnt_d;
  logic [9:0] file_index_q, file_index_d;
  logic       error_q, error_d;
  logic [4:0] step_start_q, step_start_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       finish_s;

  always_comb begin
    case (step_q)
      3'd0:    finish_s = bus.step_finish[0];
      3'd1:    finish_s = bus.step_finish[1];
      3'd2:    finish_s = bus.step_finish[2];
      3'd3:    finish_s = bus.step_finish[3];
      3'd4:    finish_s = bus.step_finish[4];
      default: finish_s = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      step_q       <= 3'd0;
      iteration_q  <= 5'd0;
      wcnt_q       <= 10'd0;
      file_index_q <= 10'd0;
      error_q      <= 1'b0;
      step_start_q <= 5'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      iteration_q  <= iteration_d;
      wcnt_q       <= wcnt_d;
      file_index_q <= file_index_d;
      error_q      <= error_d;
      step_start_q <= step_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Finish is only looked at in WAIT, so a level left high from the previous launch is harmless.
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    iteration_d  = iteration_q;
    wcnt_d       = wcnt_q;
    file_index_d = file_index_q;
    error_d      = error_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          file_index_d = bus.file_index_in;
          error_d      = 1'b0;
          iteration_d  = 5'd0;
          step_d       = 3'd0;
          state_d      = S_LAUNCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LAUNCH: begin
        wcnt_d  = 10'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (finish_s) begin
          if (step_q < 3'd4) begin
            step_d  = step_q + 3'd1;
            state_d = S_LAUNCH;
          end else if (iteration_q < LAST_ROUND) begin
            step_d      = 3'd0;
            iteration_d = iteration_q + 5'd1;
            state_d     = S_LAUNCH;
          end else begin
            state_d = S_DONE;
          end
        end else if (wcnt_q == WCNT_LAST) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else begin
          wcnt_d = wcnt_q + 10'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they appear registered in the matching cycle.
  always_comb begin
    step_start_d = 5'd0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    case (state_d)
      S_LAUNCH: begin
        step_start_d = 5'd1 << step_d;
        busy_d       = 1'b1;
      end
      S_WAIT: begin
        busy_d = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign bus.step_start = step_start_q;
  assign bus.iteration  = iteration_q;
  assign bus.file_index = file_index_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Self-checking bench for keccak_round_ctrl: stub step units with randomized finish delays
// and an event-schedule reference model of pulse times, round index, done and abort.
module tb_keccak_round_ctrl;
  localparam int NR  = 24;
  localparam int TMO = 16;
  localparam int NP  = NR * 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  keccak_round_ctrl_if bus ();
  keccak_round_ctrl #(.NUM_ROUNDS(NR), .TIMEOUT(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // planned finish delay per launch of the next job; 0 = unit never finishes
  int wplan [NP];

  // reference model: schedule of pulse cycles for the current job
  bit         m_active;
  bit         m_abort;
  int         m_acc, m_done_c, m_npulse, kp;
  int         ptime [NP];
  logic [9:0] m_tag;
  logic [4:0] e_iter;
  logic [9:0] e_fidx;
  logic       e_err;

  // stub step units
  int s_unit, s_cnt, s_pk, s_w;
  bit latched [5];
  bit xtalk;

  // observed event cycles for directed length checks
  int obs_first, obs_done, obs_last_pulse;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_outputs(input logic [4:0] e_ss, input logic e_busy, input logic e_done);
    check("step_start", 32'(bus.step_start), 32'(e_ss));
    check("busy", 32'(bus.busy), 32'(e_busy));
    check("done", 32'(bus.done), 32'(e_done));
    check("error", 32'(bus.error), 32'(e_err));
    check("iteration", 32'(bus.iteration), 32'(e_iter));
    check("file_index", 32'(bus.file_index), 32'(e_fidx));
  endtask

  function automatic bit m_idle(input int c);
    return (!m_active) || (c > m_done_c);
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_abort  = 1'b0;
    kp       = 0;
    e_iter   = 5'd0;
    e_fidx   = 10'd0;
    e_err    = 1'b0;
    s_unit   = -1;
    s_cnt    = 0;
    s_w      = 0;
    for (int u = 0; u < 5; u++) latched[u] = 1'b0;
  endtask

  // Each launch costs 1 + w cycles; a launch whose unit misses the window costs 1 + TMO and ends the job.
  task automatic accept_job(input int c, input logic [9:0] tag);
    int t;
    m_active = 1'b1;
    m_acc    = c;
    m_tag    = tag;
    m_abort  = 1'b0;
    kp       = 0;
    s_pk     = 0;
    m_npulse = 0;
    t        = c + 1;
    for (int k = 0; k < NP; k++) begin
      ptime[k] = t;
      m_npulse = k + 1;
      if (wplan[k] < 1 || wplan[k] > TMO) begin
        m_abort = 1'b1;
        t = t + TMO + 1;
        break;
      end
      t = t + 1 + wplan[k];
    end
    m_done_c = t;
  endtask

  task automatic stub_update();
    logic [4:0] fin;
    if (bus.step_start != 5'd0) begin
      for (int u = 0; u < 5; u++) if (bus.step_start[u]) s_unit = u;
      s_cnt = 0;
      s_w   = (s_pk < NP) ? wplan[s_pk] : 1;
      s_pk++;
    end else if (s_unit >= 0) begin
      s_cnt++;
    end
    fin = 5'd0;
    for (int u = 0; u < 5; u++) begin
      if (u == s_unit) begin
        if (s_cnt != 0) latched[u] = (s_w >= 1) && (s_cnt >= s_w);
        fin[u] = latched[u];
      end else begin
        fin[u] = xtalk ? 1'b1 : latched[u];
      end
    end
    bus.step_finish = fin;
  endtask

  task automatic tick(input logic st, input logic [9:0] tag);
    logic [4:0] e_ss;
    logic       e_busy, e_done;
    @(posedge clk);
    #1;
    cyc++;
    e_ss = 5'd0;
    if (m_active) begin
      if (cyc == m_acc + 1) begin
        e_err  = 1'b0;
        e_fidx = m_tag;
      end
      if (kp < m_npulse && ptime[kp] == cyc) begin
        e_ss   = 5'(1 << (kp % 5));
        e_iter = 5'(kp / 5);
        kp++;
      end
      if (cyc == m_done_c && m_abort) e_err = 1'b1;
    end
    e_busy = m_active && (cyc > m_acc) && (cyc < m_done_c);
    e_done = m_active && (cyc == m_done_c);
    check_outputs(e_ss, e_busy, e_done);
    if (bus.step_start != 5'd0) begin
      if (obs_first < 0) obs_first = cyc;
      obs_last_pulse = cyc;
    end
    if (bus.done) obs_done = cyc;
    stub_update();
    bus.start         = st;
    bus.file_index_in = tag;
    if (st && m_idle(cyc)) accept_job(cyc, tag);
  endtask

  task automatic run_until(input int target);
    while (cyc < target) tick(1'b0, 10'd0);
  endtask

  task automatic run_until_idle();
    while (!m_idle(cyc)) tick(1'b0, 10'd0);
  endtask

  task automatic fill_const(input int w);
    for (int k = 0; k < NP; k++) wplan[k] = w;
  endtask

  task automatic fill_random();
    for (int k = 0; k < NP; k++) wplan[k] = int'($urandom_range(1, TMO));
  endtask

  task automatic clear_obs();
    obs_first      = -1;
    obs_done       = -1;
    obs_last_pulse = -1;
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.start         = 1'b0;
    bus.file_index_in = 10'd0;
    bus.step_finish   = 5'd0;
    xtalk             = 1'b0;
    s_pk              = 0;
    m_done_c          = 0;
    m_acc             = 0;
    m_npulse          = 0;
    m_tag             = 10'd0;
    model_reset();
    clear_obs();
    repeat (2) @(posedge clk);
    #1;
    check_outputs(5'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick(1'b0, 10'd0);
    tick(1'b0, 10'd0);

    // nominal run, start held for two cycles, then start held through DONE for the next job
    fill_const(3);
    clear_obs();
    tick(1'b1, 10'd1);
    tick(1'b1, 10'd1);
    run_until(m_done_c - 1);
    fill_const(3);
    tick(1'b1, 10'd2);
    check("nominal_len", 32'(obs_done - obs_first), 32'd480);
    check("nominal_last_pulse", 32'(obs_last_pulse - obs_first), 32'd476);
    tick(1'b1, 10'd2);
    tick(1'b0, 10'd0);
    check("b2b_gap", 32'(cyc - obs_done), 32'd2);
    run_until_idle();

    // random delays with cross-talk on every non-active finish bit
    xtalk = 1'b1;
    fill_random();
    wplan[0] = 1;
    wplan[1] = TMO;
    tick(1'b1, 10'($urandom_range(0, 1023)));
    run_until_idle();
    xtalk = 1'b0;

    // timeout: pi never finishes in round 5
    fill_random();
    wplan[5 * 5 + 2] = 0;
    clear_obs();
    tick(1'b1, 10'h155);
    run_until_idle();
    check("abort_len", 32'(obs_done - obs_last_pulse), 32'(TMO + 1));
    check("abort_iter", 32'(bus.iteration), 32'd5);
    repeat (5) tick(1'b0, 10'd0);

    // next job clears the sticky error
    fill_random();
    tick(1'b1, 10'h2AA);
    run_until_idle();

    // reset mid-job in round 10 WAIT
    fill_random();
    wplan[50] = 5;
    clear_obs();
    tick(1'b1, 10'h0F0);
    run_until(ptime[50] + 2);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(5'd0, 1'b0, 1'b0);
    tick(1'b0, 10'd0);
    tick(1'b0, 10'd0);
    rst_n = 1'b1;
    tick(1'b0, 10'd0);
    check("no_done_on_reset", 32'(obs_done), 32'hFFFF_FFFF);

    // full job after reset, with a start pulse during round 3 that must be ignored
    fill_random();
    clear_obs();
    tick(1'b1, 10'h3C3);
    run_until(ptime[15] + 1);
    tick(1'b1, 10'h011);
    run_until_idle();
    check("busy_start_tag", 32'(bus.file_index), 32'h3C3);
    tick(1'b0, 10'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
